lsu_mem_port: RTL and testbench

Load/store unit bridging the MEM stage of the pipeline processor to the data-memory bus. It consumes the decoded memory controls `rd_en`, `wr_en` and `size`, together with the ALU address and the store data. It runs a request/grant/response handshake on the bus and stalls the pipeline until the access completes. For loads it returns byte-steered, sign- or zero-extended data to write-back.

---
 rtl/lsu_mem_port_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_mem_port.sv | 126 ++++++++++++
 tb/tb_lsu_mem_port.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// captured request record. Also holds the legality and alignment helpers.
package lsu_mem_port_pkg;

    typedef enum logic [2:0] {
        MEM_B    = 3'b000,
        MEM_H    = 3'b001,
        MEM_W    = 3'b010,
        MEM_NONE = 3'b011,
        MEM_BU   = 3'b100,
        MEM_HU   = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

    // Access captured in IDLE and held for the whole transaction
    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        mis;
    } lsu_req_t;

    // Only B/H/W/BU/HU launch a bus access; NONE and 110/111 are dropped
    function automatic logic size_legal(input logic [2:0] s);
        return (s == MEM_B) || (s == MEM_H) || (s == MEM_W) ||
               (s == MEM_BU) || (s == MEM_HU);
    endfunction

    // Address bits below the natural alignment of the access are set
    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] lo);
        return (((s == MEM_H) || (s == MEM_HU)) && lo[0]) ||
               ((s == MEM_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes / replicated store data from
// the live request, and load byte/halfword extraction with sign or zero
// extension from the returned bus word.
module lsu_align
    import lsu_mem_port_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: place the narrow datum on every lane, strobe the target one
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = wdata;
        case (st_size)
            MEM_B, MEM_BU: begin
                st_wstrb = 4'b0001 << st_lo;
                st_wdata = {4{wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                st_wstrb = 4'b0011 << {st_lo[1], 1'b0};
                st_wdata = {2{wdata[15:0]}};
            end
            MEM_W:   st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    assign ld_byte = rdata[{ld_lo, 3'b000} +: 8];
    assign ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];

    // Load side: pick the lane and extend to 32 bits
    always_comb begin
        ld_ext = 32'h0;
        case (ld_size)
            MEM_B:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            MEM_BU:  ld_ext = {24'h0, ld_byte};
            MEM_H:   ld_ext = {{16{ld_half[15]}}, ld_half};
            MEM_HU:  ld_ext = {16'h0, ld_half};
            MEM_W:   ld_ext = rdata;
            default: ld_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the MEM stage to the data-memory bus with a
// request/grant/response handshake. Stalls the pipeline while an access is
// outstanding and returns extended load data for write-back.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses skip the
// bus and raise ld_misalign / st_misalign in DONE. Without it the low
// address bits below natural alignment are simply ignored.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        ld_misalign,
    output logic        st_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_nxt;
    lsu_req_t    req_q;
    logic        legal;
    logic        mis_in;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_ext;

    assign legal = (rd_en | wr_en) && size_legal(size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = misaligned(size, addr[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    lsu_align u_align (
        .st_size  (size),
        .st_lo    (addr[1:0]),
        .wdata    (wdata),
        .st_wstrb (st_wstrb),
        .st_wdata (st_wdata),
        .ld_size  (req_q.size),
        .ld_lo    (req_q.addr[1:0]),
        .rdata    (mem_rdata),
        .ld_ext   (ld_ext)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: DONE always drains to IDLE so a held request relaunches
    // only after one idle sample
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (legal) state_nxt = mis_in ? DONE : REQ;
            REQ:     if (mem_gnt) state_nxt = req_q.we ? DONE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the access (address, size, steered store lanes) on launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req_q <= '0;
        else if (state == IDLE && legal)
            req_q <= '{we: wr_en, size: size, addr: addr,
                       wstrb: st_wstrb, wdata: st_wdata, mis: mis_in};
    end

    // Load result register, written only by a response in WAIT_R
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ld_data <= 32'h0;
        else if (state == WAIT_R && mem_rvalid)
            ld_data <= ld_ext;
    end

    // Outputs: bus fields are only driven while requesting
    always_comb begin
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0;
        mem_wstrb   = 4'h0;
        mem_wdata   = 32'h0;
        ld_valid    = 1'b0;
        ld_misalign = 1'b0;
        st_misalign = 1'b0;
        // stall reads live inputs in IDLE, so gate it off during reset
        stall = !rst && (((state != IDLE) && (state != DONE)) ||
                         ((state == IDLE) && legal));
        if (state == REQ) begin
            mem_req   = 1'b1;
            mem_we    = req_q.we;
            mem_addr  = {req_q.addr[31:2], 2'b00};
            mem_wstrb = req_q.we ? req_q.wstrb : 4'h0;
            mem_wdata = req_q.we ? req_q.wdata : 32'h0;
        end
        if (state == DONE) begin
            ld_valid = !req_q.we && !req_q.mis;
`ifdef LSU_MISALIGN_TRAP_EN
            ld_misalign = !req_q.we && req_q.mis;
            st_misalign = req_q.we && req_q.mis;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases followed by random
// accesses, each compared against an arithmetic reference model.
module tb_lsu_mem_port;

    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100, SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        stall, ld_valid, ld_misalign, st_misalign;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int passes = 0;
    int total  = 0;

    lsu_mem_port dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .size(size),
        .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_misalign(ld_misalign), .st_misalign(st_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_mis(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((s == SZ_H || s == SZ_HU) && (a % 2 != 0)) return 1'b1;
        if (s == SZ_W && (a % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] s, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (s == SZ_B || s == SZ_BU) return 4'(1 << lane);
        if (s == SZ_H || s == SZ_HU) return 4'(3 << ((lane / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] s, input logic [31:0] w);
        if (s == SZ_B || s == SZ_BU) return 32'h0101_0101 * (w % 256);
        if (s == SZ_H || s == SZ_HU) return 32'h0001_0001 * (w % 65536);
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] a,
                                             input logic [31:0] r);
        logic [31:0] v;
        int lane;
        lane = int'(a % 4);
        if (s == SZ_B || s == SZ_BU) begin
            v = (r >> (8 * lane)) % 256;
            if (s == SZ_B && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (s == SZ_H || s == SZ_HU) begin
            v = (r >> (16 * (lane / 2))) % 65536;
            if (s == SZ_H && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // ---------------- one access, driven and checked cycle by cycle ----------------
    task automatic run_access(input logic we, input logic [2:0] s, input logic [31:0] a,
                              input logic [31:0] w, input int gd, input int rdl,
                              input logic [31:0] resp,
                              output logic [31:0] o_addr, output logic [3:0] o_strb,
                              output logic [31:0] o_wdata, output logic [31:0] o_ld);
        int  cyc, reqc, waitc, stall_cnt, exp_stall;
        logic done, mis;
        mis = ref_mis(s, a);
        exp_stall = mis ? 1 : (2 + gd + (we ? 0 : rdl + 1));
        o_addr = 32'h0; o_strb = 4'h0; o_wdata = 32'h0; o_ld = 32'h0;
        cyc = 0; reqc = 0; waitc = 0; stall_cnt = 0; done = 1'b0;
        @(negedge clk);
        wr_en = we; rd_en = !we; size = s; addr = a; wdata = w;
        while (!done && cyc < 60) begin
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (cyc == 0) begin
                check("stall_launch", {31'h0, stall}, 32'h1);
                mem_gnt = 1'($urandom % 2);     // ignored in IDLE
                mem_rvalid = 1'($urandom % 2);  // ignored in IDLE
                mem_rdata = $urandom;
            end else if (mem_req === 1'b1) begin
                check("req_we", {31'h0, mem_we}, {31'h0, we});
                check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
                check("req_wstrb", {28'h0, mem_wstrb}, we ? {28'h0, ref_strb(s, a)} : 32'h0);
                check("req_wdata", mem_wdata, we ? ref_wdata(s, w) : 32'h0);
                o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata;
                mem_gnt = (reqc == gd);
                mem_rvalid = 1'($urandom % 2);  // response outside WAIT_R is ignored
                mem_rdata = $urandom;
                reqc++;
            end else if (stall === 1'b1) begin
                mem_gnt = 1'b0;
                mem_rvalid = (waitc == rdl);
                mem_rdata = (waitc == rdl) ? resp : $urandom;
                waitc++;
            end else begin
                check("done_ld_valid", {31'h0, ld_valid}, {31'h0, !we && !mis});
                check("done_ld_mis", {31'h0, ld_misalign}, {31'h0, !we && mis});
                check("done_st_mis", {31'h0, st_misalign}, {31'h0, we && mis});
                if (!we && !mis) check("done_ld_data", ld_data, ref_load(s, a, resp));
                o_ld = ld_data;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                done = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        check("access_completed", {31'h0, done}, 32'h1);
        check("stall_cycles", stall_cnt, exp_stall);
        rd_en = 1'b0; wr_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("idle_after_stall", {31'h0, stall}, 32'h0);
        check("idle_after_req", {31'h0, mem_req}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_we"}, {31'h0, mem_we}, 32'h0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_ld_data"}, ld_data, 32'h0);
        check({tag, "_ld_valid"}, {31'h0, ld_valid}, 32'h0);
        check({tag, "_flags"}, {30'h0, ld_misalign, st_misalign}, 32'h0);
    endtask

    logic [31:0] oa, ow, ol;
    logic [3:0]  os;

    initial begin
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; size = SZ_W; addr = 32'h10; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rd_en = 1'b0; rst = 1'b0;

        // SW, immediate grant
        run_access(1'b1, SZ_W, 32'h104, 32'hDEAD_BEEF, 0, 0, 32'h0, oa, os, ow, ol);
        check("sw_addr", oa, 32'h104);
        check("sw_strb", {28'h0, os}, 32'hF);
        check("sw_wdata", ow, 32'hDEAD_BEEF);

        // SB to the top lane
        run_access(1'b1, SZ_B, 32'h203, 32'h0000_00A5, 0, 0, 32'h0, oa, os, ow, ol);
        check("sb_strb", {28'h0, os}, 32'h8);
        check("sb_wdata", ow, 32'hA5A5_A5A5);

        // LB / LBU with response two cycles after grant
        run_access(1'b0, SZ_B, 32'h302, 32'h0, 0, 1, 32'h11F0_2233, oa, os, ow, ol);
        check("lb_data", ol, 32'hFFFF_FFF0);
        run_access(1'b0, SZ_BU, 32'h302, 32'h0, 0, 1, 32'h11F0_2233, oa, os, ow, ol);
        check("lbu_data", ol, 32'h0000_00F0);

        // LH with grant delayed three cycles
        run_access(1'b0, SZ_H, 32'h402, 32'h0, 3, 0, 32'h8001_0000, oa, os, ow, ol);
        check("lh_data", ol, 32'hFFFF_8001);

        // Misaligned LW
        run_access(1'b0, SZ_W, 32'h101, 32'h0, 0, 0, 32'h1234_5678, oa, os, ow, ol);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_no_bus", oa, 32'h0);
`else
        check("lw_mis_addr", oa, 32'h100);
        check("lw_mis_data", ol, 32'h1234_5678);
`endif

        // Illegal sizes launch nothing
        for (int k = 0; k < 3; k++) begin
            logic [2:0] bad [3];
            bad = '{3'b011, 3'b110, 3'b111};
            @(negedge clk);
            rd_en = 1'b1; wr_en = (k == 1); size = bad[k]; addr = 32'h40;
            #1;
            check("illegal_stall", {31'h0, stall}, 32'h0);
            @(negedge clk);
            #1;
            check("illegal_req", {31'h0, mem_req}, 32'h0);
            check("illegal_stall2", {31'h0, stall}, 32'h0);
            rd_en = 1'b0; wr_en = 1'b0;
        end

        // Reset while waiting for a load response
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; size = SZ_W; addr = 32'h500;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("waitr_stall", {31'h0, stall}, 32'h1);
        check("waitr_req", {31'h0, mem_req}, 32'h0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("late_rv_ld_valid", {31'h0, ld_valid}, 32'h0);
        check("late_rv_ld_data", ld_data, 32'h0);
        check("late_rv_stall", {31'h0, stall}, 32'h0);
        run_access(1'b1, SZ_W, 32'h600, 32'h0BAD_CAFE, 0, 0, 32'h0, oa, os, ow, ol);
        check("post_rst_sw_addr", oa, 32'h600);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            logic [2:0] szs [5];
            logic [2:0] s;
            szs = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
            s = szs[$urandom_range(0, 4)];
            run_access(1'($urandom % 2), s, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       $urandom, oa, os, ow, ol);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
